cpu_ctrl: RTL
=============

Name: cpu_ctrl

Overview:
- Multi-cycle control FSM for the 8-bit accumulator CPU.
- Fetches instructions over a req/valid handshake, decodes them, and drives the combinational ALU select. Also generates the accumulator/register-file write strobes and keeps the PC and the Z/C status flags.
- Sits between instruction memory, the register file, the accumulator and the ALU.

Parameters:
- PC_W, 8, program counter width; PC arithmetic is modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- instr_req  out  1  fetch request; high only in FETCH.
- pc  out  PC_W  fetch address; stable while instr_req is high.
- instr_valid  in  1  instruction memory has instr_data for pc.
- instr_data  in  8  instruction; [7:4] opcode, [3:0] operand.
- alu_z  in  1  ALU zero output, combinational.
- alu_c  in  1  ALU carry/borrow output, combinational.
- alu_sel  out  4  ALU opcode.
- accum_we  out  1  accumulator loads the ALU result this edge.
- reg_we  out  1  register file writes the accumulator to reg_addr this edge.
- reg_addr  out  4  register index, equal to IR[3:0].
- flag_z  out  1  latched zero flag.
- flag_c  out  1  latched carry flag.
- halted  out  1  CPU is in HALT.
- illegal  out  1  undefined opcode trapped; see Optional Feature.

Behaviour:
Reset values:
- State FETCH, pc = RESET_PC, IR = 0, flag_z = 0, flag_c = 0.
- All strobes 0, alu_sel = 0, halted = 0, illegal = 0.
- Reset asserted in any state aborts the current operation; no write strobe fires during reset.

Opcode map:
- ALU ops: 0000 NOP, 0001 ADD, 0010 SUB, 0011 NOR, 0100 MOVR, 1011 SHL, 1100 SHR.
- 0101 STA: reg[IR[3:0]] <= accum.
- 0110 JZ, 0111 JC.
- 1111 HALT.
- 1000, 1001, 1010, 1101, 1110 undefined.

States:
- FETCH:
  - instr_req = 1.
  - On instr_valid: IR <= instr_data, go to DECODE.
  - Otherwise hold; unbounded wait is allowed.
  - instr_valid is ignored in every other state.
- DECODE (1 cycle):
  - ALU op: go to EXEC.
  - STA: go to WRITE.
  - JZ: if flag_z, pc <= pc + sext(IR[3:0]); else pc <= pc + 1. Go to FETCH.
  - JC: same rule as JZ, using flag_c.
  - NOP: pc <= pc + 1, go to FETCH.
  - HALT: go to HALT.
  - Undefined: treated as NOP.
- EXEC (1 cycle):
  - alu_sel = IR[7:4], accum_we = 1.
  - flag_z <= alu_z, flag_c <= alu_c, sampled on the same edge as the accumulator write.
  - pc <= pc + 1, go to FETCH.
- WRITE (1 cycle):
  - reg_we = 1, flags unchanged.
  - pc <= pc + 1, go to FETCH.
- HALT:
  - halted = 1, instr_req = 0, pc frozen.
  - Exit only by reset.

Output rules:
- Outside EXEC: alu_sel = 0, accum_we = 0.
- reg_addr = IR[3:0] in all states.
- Strobes are combinational from state and are one cycle wide.
- Flags change only in EXEC.

Latency (fetch granted on its first cycle):
- ALU op: 3 cycles.
- STA: 3 cycles.
- Jump, NOP: 2 cycles.

Boundary conditions:
- PC wraps: 2^PC_W - 1 + 1 -> 0.
- Relative jump wraps modulo 2^PC_W; offset range -8..+7.
- JZ with offset 0 loops on itself.
- instr_valid high on the same cycle reset deasserts: ignored, because FETCH is entered with the request only after reset.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE goes to HALT with illegal = 1; halted and illegal stay high until reset; pc stays at the offending instruction.
- Not defined: undefined opcodes execute as NOP and illegal is tied 0.

Decomposition:
- Package cpu_pkg:
  - opcode localparams: OP_NOP, OP_ADD, OP_SUB, OP_NOR, OP_MOVR, OP_STA, OP_JZ, OP_JC, OP_SHL, OP_SHR, OP_HALT.
  - state encoding: S_FETCH, S_DECODE, S_EXEC, S_WRITE, S_HALT.
  - shared with the ALU and the testbench.
- Sub-module cpu_decode: combinational; maps opcode to is_alu, is_sta, is_jz, is_jc, is_halt, is_undef.

Test Plan:
- Reset, then program {0x4_3 MOVR r3, 0x1_2 ADD r2}, instr_valid same-cycle -> accum_we pulses at cycles 3 and 6, alu_sel 0100 then 0001, pc ends at 2.
- SUB with ALU returning alu_z = 1, alu_c = 1 -> flag_z = flag_c = 1 after EXEC; a following JZ with offset 0xE -> pc = 2 - 2 + 1... i.e. jump to pc - 2 from the JZ address.
- JC with flag_c = 0 at pc = 0xFF -> pc wraps to 0x00; JZ with flag_z = 1, offset +7, at pc = 0xFC -> pc = 0x03.
- instr_valid held low 5 cycles in FETCH -> instr_req stays 1, pc stable, no strobes; STA r5 -> reg_we for 1 cycle with reg_addr = 5.
- HALT (0xF0) -> halted = 1, instr_req = 0 forever; assert rst mid-EXEC of a later run -> accum_we drops immediately, pc = RESET_PC.
- Opcode 0x9 -> with ILLEGAL_TRAP_EN: halted = illegal = 1, pc unchanged; without: pc + 1, illegal = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcode map and control
// FSM state encoding. Used by the ALU, the control block and the testbench.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_NOR  = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_STA  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WRITE  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_decode.sv
// Opcode classifier for the control FSM. Purely combinational; NOP matches
// no class, so the FSM handles it with its default path.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_sta,
  output logic       is_jz,
  output logic       is_jc,
  output logic       is_halt,
  output logic       is_undef
);

  // One-hot class of the current opcode.
  always_comb begin
    is_alu   = 1'b0;
    is_sta   = 1'b0;
    is_jz    = 1'b0;
    is_jc    = 1'b0;
    is_halt  = 1'b0;
    is_undef = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_NOR, OP_MOVR, OP_SHL, OP_SHR: is_alu = 1'b1;
      OP_STA:  is_sta  = 1'b1;
      OP_JZ:   is_jz   = 1'b1;
      OP_JC:   is_jc   = 1'b1;
      OP_HALT: is_halt = 1'b1;
      OP_NOP:  ;
      default: is_undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM for the 8-bit accumulator CPU: fetch over a
// req/valid handshake, decode, drive ALU select and write strobes, keep PC
// and Z/C flags. Optional macro ILLEGAL_TRAP_EN: undefined opcodes halt the
// CPU with illegal=1 instead of executing as NOP.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  input  logic            instr_valid,
  input  logic [7:0]      instr_data,
  input  logic            alu_z,
  input  logic            alu_c,
  output logic [3:0]      alu_sel,
  output logic            accum_we,
  output logic            reg_we,
  output logic [3:0]      reg_addr,
  output logic            flag_z,
  output logic            flag_c,
  output logic            halted,
  output logic            illegal
);

  state_t          state, state_nxt;
  logic [7:0]      ir;
  logic [PC_W-1:0] pc_nxt, pc_inc, pc_rel;
  logic            is_alu, is_sta, is_jz, is_jc, is_halt, is_undef;

  cpu_decode u_dec (
    .opcode   (ir[7:4]),
    .is_alu   (is_alu),
    .is_sta   (is_sta),
    .is_jz    (is_jz),
    .is_jc    (is_jc),
    .is_halt  (is_halt),
    .is_undef (is_undef)
  );

  // Sequential and relative (sign-extended 4-bit offset) PC targets; both
  // wrap naturally at PC_W bits.
  assign pc_inc = pc + PC_W'(1);
  assign pc_rel = pc + {{(PC_W-4){ir[3]}}, ir[3:0]};

  // State and PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Instruction register loads on a granted fetch; flags load only with
  // the accumulator write in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      if (state == S_FETCH && instr_valid) ir <= instr_data;
      if (state == S_EXEC) begin
        flag_z <= alu_z;
        flag_c <= alu_c;
      end
    end
  end

  // Next-state, PC update and strobes; strobes depend on state only.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_req = 1'b0;
    alu_sel   = 4'h0;
    accum_we  = 1'b0;
    reg_we    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu) state_nxt = S_EXEC;
        else if (is_sta) state_nxt = S_WRITE;
        else if (is_halt) state_nxt = S_HALT;
        else if (is_jz) begin
          pc_nxt    = flag_z ? pc_rel : pc_inc;
          state_nxt = S_FETCH;
        end else if (is_jc) begin
          pc_nxt    = flag_c ? pc_rel : pc_inc;
          state_nxt = S_FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        // Trap leaves pc on the offending instruction.
        else if (is_undef) state_nxt = S_HALT;
`else
        else if (is_undef) begin
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
        end
`endif
        else begin
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_sel   = ir[7:4];
        accum_we  = 1'b1;
        pc_nxt    = pc_inc;
        state_nxt = S_FETCH;
      end
      S_WRITE: begin
        reg_we    = 1'b1;
        pc_nxt    = pc_inc;
        state_nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign reg_addr = ir[3:0];

`ifdef ILLEGAL_TRAP_EN
  // IR still holds the trapping opcode while halted.
  assign illegal = (state == S_HALT) && is_undef;
`else
  assign illegal = 1'b0;
`endif

endmodule
